// File: rtl/ota_cal_ctrl_if.sv
// Control/sense bundle between the OTA calibration sequencer and its host/analog side.
// The slave modport is the sequencer's view.
interface ota_cal_ctrl_if #(
    parameter int TRIM_W   = 6,
    parameter int SETTLE_W = 8
);
    logic                ena;
    logic                cal_start;
    logic [SETTLE_W-1:0] settle_cyc;
    logic                man_sel;
    logic [TRIM_W-1:0]   man_trim;
    logic                cmp_async;
    logic                ota_en;
    logic                short_in;
    logic [TRIM_W-1:0]   trim;
    logic                busy;
    logic                done;
    logic                cal_err;

    modport slave (
        input  ena, cal_start, settle_cyc, man_sel, man_trim, cmp_async,
        output ota_en, short_in, trim, busy, done, cal_err
    );

    modport master (
        output ena, cal_start, settle_cyc, man_sel, man_trim, cmp_async,
        input  ota_en, short_in, trim, busy, done, cal_err
    );
endinterface

// File: rtl/ota_cal_ctrl.sv
// OTA power-up and successive-approximation offset-trim sequencer.
// Shorts the OTA inputs, resolves one trim bit per step from the synced comparator, then holds the code.
module ota_cal_ctrl #(
    parameter int TRIM_W    = 6,
    parameter int SETTLE_W  = 8,
    parameter int PWRUP_CYC = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    ota_cal_ctrl_if.slave bus
);
    localparam int PW_W  = $clog2(PWRUP_CYC + 1);
    localparam int CNT_W = (SETTLE_W > PW_W) ? SETTLE_W : PW_W;
    localparam int K_W   = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
    localparam logic [TRIM_W-1:0] MID = TRIM_W'(1) << (TRIM_W - 1);

    typedef enum logic [2:0] {IDLE, PWRUP, STEP, SAMPLE, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [TRIM_W-1:0]   trim_q, trim_d;
    logic [SETTLE_W-1:0] s_q, s_d;
    logic                cal_err_q, cal_err_d;
    logic                cmp_meta_q, cmp_s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            k_q        <= '0;
            trim_q     <= MID;
            s_q        <= '0;
            cal_err_q  <= 1'b0;
            cmp_meta_q <= 1'b0;
            cmp_s_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            trim_q     <= trim_d;
            s_q        <= s_d;
            cal_err_q  <= cal_err_d;
            cmp_meta_q <= bus.cmp_async;
            cmp_s_q    <= cmp_meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        trim_d    = trim_q;
        s_d       = s_q;
        cal_err_d = cal_err_q;
        if (!bus.ena) begin
            state_d   = IDLE;
            trim_d    = MID;
            cal_err_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.cal_start) begin
                        state_d   = PWRUP;
                        trim_d    = '0;
                        cal_err_d = 1'b0;
                        cnt_d     = CNT_W'(PWRUP_CYC);
                        s_d       = (bus.settle_cyc == '0) ? SETTLE_W'(1) : bus.settle_cyc;
                    end
                end
                PWRUP: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d           = STEP;
                        k_d               = K_W'(TRIM_W - 1);
                        trim_d[TRIM_W-1]  = 1'b1;
                        cnt_d             = CNT_W'(s_q);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                STEP: begin
                    if (cnt_q == CNT_W'(1)) state_d = SAMPLE;
                    else                    cnt_d   = cnt_q - CNT_W'(1);
                end
                SAMPLE: begin
                    // Resolve bit k and, if more remain, tentatively set the next lower bit in the same cycle.
                    if (cmp_s_q) trim_d[k_q] = 1'b0;
                    if (k_q != '0) begin
                        k_d         = k_q - K_W'(1);
                        trim_d[k_d] = 1'b1;
                        cnt_d       = CNT_W'(s_q);
                        state_d     = STEP;
                    end else begin
                        state_d   = DONE;
                        cal_err_d = (trim_d == '0) || (trim_d == '1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    logic busy_w;
    assign busy_w       = (state_q == PWRUP) || (state_q == STEP) || (state_q == SAMPLE);
    assign bus.busy     = busy_w;
    assign bus.short_in = busy_w;
    assign bus.ota_en   = busy_w || (state_q == DONE);
    assign bus.done     = (state_q == DONE);
    assign bus.cal_err  = cal_err_q;
    assign bus.trim     = (bus.man_sel && !busy_w) ? bus.man_trim : trim_q;
endmodule

// File: tb/tb_ota_cal_ctrl.sv
// Directed bench for ota_cal_ctrl: SAR sequences, timing, abort, reset and manual override.
module tb_ota_cal_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ota_cal_ctrl_if #(.TRIM_W(6), .SETTLE_W(8)) bus ();

    ota_cal_ctrl #(.TRIM_W(6), .SETTLE_W(8), .PWRUP_CYC(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    bit   use_model = 1'b0;
    logic cmp_force = 1'b0;
    int   repulse_at = -1;
    int   drop_at = -1;
    logic [5:0] codes[$];
    bit   short_ok;

    // Behavioural OTA: offset positive when trim exceeds the ideal code 37.
    assign bus.cmp_async = use_model ? (bus.trim > 6'd37) : cmp_force;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cal(output int cyc, output bit aborted);
        logic [5:0] last;
        bus.cal_start = 1'b1;
        tick();
        bus.cal_start = 1'b0;
        codes.delete();
        last     = bus.trim;
        cyc      = 0;
        aborted  = 1'b0;
        short_ok = 1'b1;
        while (bus.busy === 1'b1 && cyc < 300) begin
            cyc++;
            if (bus.short_in !== 1'b1) short_ok = 1'b0;
            if (bus.trim !== last) begin
                codes.push_back(bus.trim);
                last = bus.trim;
            end
            if (cyc == repulse_at) begin
                bus.cal_start  = 1'b1;
                bus.settle_cyc = 8'd0;
            end else begin
                bus.cal_start = 1'b0;
            end
            if (cyc == drop_at) begin
                bus.ena = 1'b0;
                tick();
                aborted = 1'b1;
                break;
            end
            tick();
        end
        bus.cal_start = 1'b0;
    endtask

    initial begin
        int cyc;
        bit ab;
        logic [5:0] exp_a[6] = '{6'd32, 6'd48, 6'd56, 6'd60, 6'd62, 6'd63};
        logic [5:0] exp_b[6] = '{6'd32, 6'd48, 6'd40, 6'd36, 6'd38, 6'd37};

        rst_n          = 1'b0;
        bus.ena        = 1'b1;
        bus.cal_start  = 1'b0;
        bus.settle_cyc = 8'd4;
        bus.man_sel    = 1'b0;
        bus.man_trim   = 6'h00;
        tick(); tick();
        chk("rst_busy",   bus.busy,     1'b0);
        chk("rst_done",   bus.done,     1'b0);
        chk("rst_ota_en", bus.ota_en,   1'b0);
        chk("rst_short",  bus.short_in, 1'b0);
        chk("rst_err",    bus.cal_err,  1'b0);
        chk("rst_trim",   bus.trim,     6'h20);
        rst_n = 1'b1;
        tick(); tick();

        // All-zero comparator: every bit kept.
        cmp_force = 1'b0;
        run_cal(cyc, ab);
        chk("a_cycles",  cyc,          94);
        chk("a_short",   short_ok,     1'b1);
        chk("a_done",    bus.done,     1'b1);
        chk("a_short_o", bus.short_in, 1'b0);
        chk("a_ota_en",  bus.ota_en,   1'b1);
        chk("a_trim",    bus.trim,     6'h3F);
        chk("a_err",     bus.cal_err,  1'b1);
        chk("a_ncodes",  codes.size(), 6);
        for (int i = 0; i < 6 && i < codes.size(); i++) chk("a_code", codes[i], exp_a[i]);

        // OTA model with ideal code 37, restarted from DONE.
        use_model = 1'b1;
        run_cal(cyc, ab);
        chk("b_cycles", cyc,          94);
        chk("b_ncodes", codes.size(), 6);
        for (int i = 0; i < 6 && i < codes.size(); i++) chk("b_code", codes[i], exp_b[i]);
        chk("b_trim",   bus.trim,    6'h25);
        chk("b_err",    bus.cal_err, 1'b0);
        chk("b_done",   bus.done,    1'b1);

        // settle_cyc=0 behaves as 1; comparator always high.
        use_model      = 1'b0;
        cmp_force      = 1'b1;
        bus.settle_cyc = 8'd0;
        tick(); tick(); tick();
        run_cal(cyc, ab);
        chk("c_cycles", cyc,         76);
        chk("c_trim",   bus.trim,    6'h00);
        chk("c_err",    bus.cal_err, 1'b1);

        // Re-pulse of cal_start and settle_cyc change while busy are ignored.
        cmp_force      = 1'b0;
        bus.settle_cyc = 8'd4;
        tick(); tick(); tick();
        repulse_at = 70;
        run_cal(cyc, ab);
        repulse_at     = -1;
        bus.settle_cyc = 8'd4;
        chk("d_cycles", cyc,      94);
        chk("d_trim",   bus.trim, 6'h3F);
        tick(); tick();
        chk("d_done",   bus.done, 1'b1);
        chk("d_busy",   bus.busy, 1'b0);

        // ena drop aborts mid-calibration.
        drop_at = 80;
        run_cal(cyc, ab);
        drop_at = -1;
        chk("e_aborted", ab,         1'b1);
        chk("e_ota_en",  bus.ota_en, 1'b0);
        chk("e_busy",    bus.busy,   1'b0);
        chk("e_done",    bus.done,   1'b0);
        chk("e_short",   bus.short_in, 1'b0);
        chk("e_trim",    bus.trim,   6'h20);
        bus.ena = 1'b1;
        tick(); tick();
        chk("e_idle",    bus.busy,   1'b0);

        // Asynchronous reset mid-STEP.
        bus.cal_start = 1'b1;
        tick();
        bus.cal_start = 1'b0;
        repeat (70) tick();
        chk("f_pre_busy", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("f_ota_en", bus.ota_en,   1'b0);
        chk("f_short",  bus.short_in, 1'b0);
        chk("f_busy",   bus.busy,     1'b0);
        chk("f_done",   bus.done,     1'b0);
        chk("f_trim",   bus.trim,     6'h20);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("f_idle_busy", bus.busy,   1'b0);
        chk("f_idle_ota",  bus.ota_en, 1'b0);

        // Manual override.
        bus.man_sel  = 1'b1;
        bus.man_trim = 6'h15;
        tick();
        chk("g_man_idle", bus.trim, 6'h15);
        use_model = 1'b1;
        run_cal(cyc, ab);
        chk("g_cycles", cyc, 94);
        chk("g_code0",  (codes.size() > 0) ? codes[0] : 6'h00, 6'd32);
        chk("g_ncodes", codes.size(), 6);
        chk("g_man_done", bus.trim, 6'h15);
        bus.man_sel = 1'b0;
        #1;
        chk("g_cal_code", bus.trim, 6'h25);
        chk("g_done",     bus.done, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ota_cal_ctrl.md
Name: ota_cal_ctrl

Overview:
- Digital sequencer for the on-chip analog OTA: powers it up, shorts its inputs and runs a successive-approximation offset-trim calibration.
- Uses a comparator sense of the OTA output on each step, then releases the inputs and holds the trim code.
- Sits in the tt_um digital domain between the dedicated ui_in/uo_out pins and the OTA's enable, input-short switch and trim-DAC controls.
- Also lets the host override the trim code manually when no calibration is running.

Parameters:
TRIM_W, 6, width of offset-trim code driven to the OTA trim DAC
SETTLE_W, 8, width of runtime settle-count input
PWRUP_CYC, 64, cycles OTA is held enabled and shorted before the first trim step (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  block enable; low aborts and holds IDLE
cal_start  input  1  calibration request, level sampled each cycle
settle_cyc  input  SETTLE_W  settle cycles per trim step, latched at start; 0 treated as 1
man_sel  input  1  1 = drive trim from man_trim when not busy
man_trim  input  TRIM_W  manual trim code
cmp_async  input  1  OTA output comparator, asynchronous; 1 = offset positive (trim too high)
ota_en  output  1  OTA bias enable
short_in  output  1  closes OTA input-short switch
trim  output  TRIM_W  trim code to OTA DAC
busy  output  1  calibration in progress
done  output  1  calibration completed, trim valid
cal_err  output  1  final code saturated (all-zeros or all-ones)

Behaviour:
- Reset values: ota_en=0, short_in=0, internal trim register = midscale (1<<(TRIM_W-1)), busy=0, done=0, cal_err=0, sync flops=0, state=IDLE.
- cmp_async passes through a 2-flop synchronizer (cmp_s). Only cmp_s is used.
- States: IDLE, PWRUP, STEP, SAMPLE, DONE.
- IDLE/DONE: cal_start=1 with ena=1 at a clock edge has these effects from the next cycle:
  - state=PWRUP, busy=1, done=0, cal_err=0, ota_en=1, short_in=1, trim register=0.
  - S = max(settle_cyc,1) is latched and the counter is loaded with PWRUP_CYC.
- PWRUP: lasts exactly PWRUP_CYC cycles. Then bit index k=TRIM_W-1; entering STEP sets trim[k]=1 and loads the counter with S.
- STEP: lasts exactly S cycles, then SAMPLE.
- SAMPLE (1 cycle):
  - If cmp_s=1, clear trim[k]; otherwise keep it.
  - If k>0: k=k-1 and go to STEP (which sets the new bit).
  - If k=0: go to DONE.
- Total busy time = PWRUP_CYC + TRIM_W*(S+1) cycles.
- DONE: busy=0, done=1, short_in=0, ota_en stays 1, trim register held. cal_err=1 if final code is 0 or 2^TRIM_W-1.
- trim output:
  - Equals man_trim when man_sel=1 and busy=0.
  - Otherwise equals the trim register.
  - man_sel is ignored while busy.
- cal_start while busy: ignored. Holding cal_start high in DONE restarts calibration every time it completes.
- ena=0 (any state, synchronous):
  - Next cycle: state=IDLE, ota_en=0, short_in=0, busy=0, done=0, cal_err=0, trim register=midscale.
  - ena has priority over cal_start.
- rst_n low mid-calibration: immediately returns all outputs to reset values. No calibration resumes after reset is released.
- settle_cyc changes during busy have no effect.

Test Plan:
- Reset: assert rst_n=0 mid-STEP -> ota_en=0, short_in=0, busy=0, done=0, trim=0x20 immediately; stays IDLE after release with cal_start=0.
- Defaults, settle_cyc=4, cmp_async held 0, pulse cal_start -> busy high exactly 94 cycles, short_in=1 throughout busy, then done=1, short_in=0, ota_en=1, trim=0x3F, cal_err=1.
- Behavioural OTA model cmp_async = (trim > 37), settle_cyc=4 -> step codes tested 32,48,40,36,38,37 -> final trim=37 (0x25), cal_err=0, done=1.
- settle_cyc=0, cmp_async held 1 -> busy 76 cycles, final trim=0x00, cal_err=1.
- Mid-calibration: cal_start re-pulsed at cycle 70 -> no effect, finish at cycle 94. Separate run: ena=0 at cycle 80 -> next cycle IDLE, ota_en=0, busy=0, done=0, trim=0x20.
- man_sel=1, man_trim=0x15, idle -> trim=0x15. Start calibration with man_sel=1 -> trim follows the SAR register while busy. After done, trim returns to 0x15; man_sel=0 then shows the calibrated code.
